recirc_oeo_buffer: RTL and testbench

// - Per-input-port OEO recirculation buffer; one instance per port, upstream of alloc_recirc.
// - Captures packets that lost speculative arbitration, presents one buffer request per stored packet on
//   req_buf, and replays the head packet for one slot after grant_buf.
// - Packets are held in FIFO order. Only the head packet is ever requested, so a grant always refers to the head.

---
 rtl/recirc_oeo_buffer_pkg.sv | 38 +++
 rtl/recirc_oeo_buffer_if.sv | 26 ++
 rtl/recirc_oeo_buffer_slot_mem.sv | 24 ++
 rtl/recirc_oeo_buffer.sv | 152 +++++++++++++++
 tb/tb_recirc_oeo_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/recirc_oeo_buffer_pkg.sv
// Shared configuration for the OEO recirculation buffer: sizes, request/grant
// types and the read-side state encoding.
package recirc_oeo_buffer_pkg;

   function automatic int unsigned log2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r = r + 1;
      return r;
   endfunction

   localparam int unsigned PORTS      = 8;
   localparam int unsigned SLOT_SIZE  = 4;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned DATA_W     = 32;

   localparam int unsigned DEST_W = log2(PORTS);
   localparam int unsigned PTR_W  = log2(FIFO_DEPTH);
   localparam int unsigned WORD_W = log2(SLOT_SIZE);
   localparam int unsigned OCC_W  = PTR_W + 1;

   typedef struct packed {
      logic              valid;
      logic [DEST_W-1:0] port;
   } req_t;

   typedef struct packed {
      logic valid;
   } grant_t;

   typedef enum logic [1:0] {RB_IDLE, RB_REQ, RB_WAIT, RB_SEND} rb_state_t;

   // Slot pointers wrap explicitly so a non-power-of-two depth still works.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/recirc_oeo_buffer_if.sv
// Capture, allocator handshake and replay signals of one recirculation buffer.
// slave is the buffer's view; master is the upstream/allocator/switch side.
interface recirc_oeo_buffer_if;
   import recirc_oeo_buffer_pkg::*;

   logic              in_valid;
   logic              in_sop;
   logic [DATA_W-1:0] in_data;
   req_t              req_buf;
   grant_t            grant_buf;
   logic              out_valid;
   logic              out_sop;
   logic [DATA_W-1:0] out_data;
   logic [OCC_W-1:0]  occupancy;
   logic              drop;

   modport slave (
      input  in_valid, in_sop, in_data, grant_buf,
      output req_buf, out_valid, out_sop, out_data, occupancy, drop
   );

   modport master (
      output in_valid, in_sop, in_data, grant_buf,
      input  req_buf, out_valid, out_sop, out_data, occupancy, drop
   );
endinterface

// File: rtl/recirc_oeo_buffer_slot_mem.sv
// Packet slot storage: FIFO_DEPTH slots of SLOT_SIZE words, one synchronous
// write port and one combinational read port. Data is not reset.
module recirc_slot_mem
   import recirc_oeo_buffer_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  wslot,
   input  logic [WORD_W-1:0] wword,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  rslot,
   input  logic [WORD_W-1:0] rword,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH][SLOT_SIZE];

   always_ff @(posedge clk) begin
      if (we) mem[wslot][wword] <= wdata;
   end

   assign rdata = mem[rslot][rword];

endmodule

// File: rtl/recirc_oeo_buffer.sv
// Per-port recirculation buffer: captures whole packets into a slot FIFO,
// requests the allocator once per packet and replays the head on grant.
module recirc_oeo_buffer
   import recirc_oeo_buffer_pkg::*;
(
   input logic               clk,
   input logic               rst,
   recirc_oeo_buffer_if.slave bus
);

   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(SLOT_SIZE - 1);
   localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(FIFO_DEPTH);

   rb_state_t         state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WORD_W-1:0] wr_word_q, wr_word_d, rd_word_q, rd_word_d;
   logic              cap_q, cap_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              out_valid_q, out_valid_d, out_sop_q, out_sop_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   logic              mem_we;
   logic [WORD_W-1:0] mem_wword;
   logic [DATA_W-1:0] rd_data;
   logic              commit, retire, full, drop;
   req_t              req;

   recirc_slot_mem u_mem (
      .clk   (clk),
      .we    (mem_we),
      .wslot (wr_ptr_q),
      .wword (mem_wword),
      .wdata (bus.in_data),
      .rslot (rd_ptr_q),
      .rword (rd_word_q),
      .rdata (rd_data)
   );

   assign full = (occ_q == FULL_OCC);

   // Capture side. A new sop during a capture restarts at the same slot, so the
   // partial packet is simply overwritten and never committed.
   always_comb begin
      cap_d     = cap_q;
      wr_word_d = wr_word_q;
      mem_we    = 1'b0;
      mem_wword = wr_word_q;
      commit    = 1'b0;
      drop      = 1'b0;
      if (bus.in_valid && bus.in_sop) begin
         drop = cap_q || full;
         if (cap_q || !full) begin
            mem_we    = 1'b1;
            mem_wword = '0;
            cap_d     = 1'b1;
            wr_word_d = WORD_W'(1);
         end
      end else if (bus.in_valid && cap_q) begin
         mem_we = 1'b1;
         if (wr_word_q == LAST_WORD) begin
            commit    = 1'b1;
            cap_d     = 1'b0;
            wr_word_d = '0;
         end else begin
            wr_word_d = wr_word_q + WORD_W'(1);
         end
      end
   end

   assign wr_ptr_d = commit ? next_ptr(wr_ptr_q) : wr_ptr_q;

   // Read FSM. rd_word_q stays 0 outside SEND, so rd_data holds head word 0
   // (and thus the destination) while requesting and waiting.
   always_comb begin
      state_d     = state_q;
      rd_word_d   = rd_word_q;
      rd_ptr_d    = rd_ptr_q;
      retire      = 1'b0;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_data_d  = '0;
      req         = '0;
      case (state_q)
         RB_IDLE: begin
            if (occ_q != '0) state_d = RB_REQ;
         end
         RB_REQ: begin
            req.valid = 1'b1;
            req.port  = rd_data[DEST_W-1:0];
            state_d   = RB_WAIT;
         end
         RB_WAIT: begin
            if (bus.grant_buf.valid) begin
               out_valid_d = 1'b1;
               out_sop_d   = 1'b1;
               out_data_d  = rd_data;
               rd_word_d   = WORD_W'(1);
               state_d     = RB_SEND;
            end
         end
         RB_SEND: begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            if (rd_word_q == LAST_WORD) begin
               retire    = 1'b1;
               rd_word_d = '0;
               rd_ptr_d  = next_ptr(rd_ptr_q);
               state_d   = RB_IDLE;
            end else begin
               rd_word_d = rd_word_q + WORD_W'(1);
            end
         end
         default: state_d = RB_IDLE;
      endcase
   end

   assign occ_d = occ_q + OCC_W'(commit) - OCC_W'(retire);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RB_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wr_word_q   <= '0;
         rd_word_q   <= '0;
         cap_q       <= 1'b0;
         occ_q       <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_word_q   <= wr_word_d;
         rd_word_q   <= rd_word_d;
         cap_q       <= cap_d;
         occ_q       <= occ_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.req_buf   = req;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sop   = out_sop_q;
   assign bus.out_data  = out_data_q;
   assign bus.occupancy = occ_q;
   assign bus.drop      = drop;

endmodule

// File: tb/tb_recirc_oeo_buffer.sv
// Directed bench for recirc_oeo_buffer: single packet, fill/drop, FIFO order,
// simultaneous commit/retire, aborted capture and mid-replay reset.
module tb_recirc_oeo_buffer;
   import recirc_oeo_buffer_pkg::*;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   req_cnt = 0;
   logic [2:0] req_ports [64];

   recirc_oeo_buffer_if bus ();

   recirc_oeo_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every request pulse (REQ lasts exactly one cycle, so one sample each).
   always @(negedge clk) begin
      if (bus.req_buf.valid) begin
         if (req_cnt < 64) req_ports[req_cnt] = bus.req_buf.port;
         req_cnt = req_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required a self-terminating run");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pkt_word(input logic [7:0] tag, input int i,
                                            input logic [2:0] dest);
      logic [7:0] idx;
      logic [7:0] low;
      idx = 8'(i);
      low = (i == 0) ? {5'b0, dest} : 8'h00;
      return {8'hA0, tag, idx, low};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [7:0] tag, input logic [2:0] dest, output logic dropped);
      dropped = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.in_valid = 1'b1;
         bus.in_sop   = (i == 0);
         bus.in_data  = pkt_word(tag, i, dest);
         if (i == 0) begin
            #1;
            dropped = bus.drop;
         end
      end
   endtask

   task automatic end_pkt();
      tick();
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_data  = '0;
   endtask

   // Called with the FSM in WAIT: grant now, expect words on the next four cycles.
   task automatic replay(input logic [7:0] tag, input logic [2:0] dest, input string lbl);
      bus.grant_buf.valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.grant_buf.valid = 1'b0;
         check($sformatf("%s_valid%0d", lbl, i), 32'(bus.out_valid), 32'd1);
         check($sformatf("%s_sop%0d", lbl, i), 32'(bus.out_sop), 32'(i == 0));
         check($sformatf("%s_data%0d", lbl, i), bus.out_data, pkt_word(tag, i, dest));
         check($sformatf("%s_noreq%0d", lbl, i), 32'(bus.req_buf.valid), 32'd0);
      end
   endtask

   task automatic wait_req(input int n, input logic [2:0] dest, input string lbl);
      int k;
      k = 0;
      while (req_cnt < n && k < 40) begin
         tick();
         k++;
      end
      check({lbl, "_seen"}, 32'(req_cnt >= n), 32'd1);
      if (req_cnt >= n) check({lbl, "_port"}, 32'(req_ports[n-1]), 32'(dest));
      tick();
   endtask

   initial begin
      logic d;
      logic [4:0] fd;
      int base;

      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sop = 1'b0;
      bus.in_data = '0;
      bus.grant_buf = '0;
      tick();
      tick();
      check("rst_req", 32'(bus.req_buf.valid), 32'd0);
      check("rst_out", 32'(bus.out_valid), 32'd0);
      check("rst_occ", 32'(bus.occupancy), 32'd0);
      check("rst_drop", 32'(bus.drop), 32'd0);
      rst = 1'b1;
      tick();

      // Stray grant while idle is ignored.
      bus.grant_buf.valid = 1'b1;
      tick();
      bus.grant_buf.valid = 1'b0;
      check("stray_grant_out", 32'(bus.out_valid), 32'd0);
      tick();
      check("stray_grant_out2", 32'(bus.out_valid), 32'd0);

      // Single packet to dest 5.
      send_pkt(8'h01, 3'd5, d);
      check("single_drop", 32'(d), 32'd0);
      end_pkt();
      check("single_occ1", 32'(bus.occupancy), 32'd1);
      check("single_noreq_yet", 32'(bus.req_buf.valid), 32'd0);
      tick();
      check("single_req", 32'(bus.req_buf.valid), 32'd1);
      check("single_port", 32'(bus.req_buf.port), 32'd5);
      tick();
      check("single_req_pulse", 32'(bus.req_buf.valid), 32'd0);
      replay(8'h01, 3'd5, "single");
      check("single_occ0", 32'(bus.occupancy), 32'd0);
      tick();
      check("single_out_end", 32'(bus.out_valid), 32'd0);

      // Fill: five back-to-back packets, no grants; fifth is dropped.
      base = req_cnt;
      send_pkt(8'h11, 3'd1, fd[0]);
      send_pkt(8'h12, 3'd2, fd[1]);
      send_pkt(8'h13, 3'd3, fd[2]);
      send_pkt(8'h14, 3'd4, fd[3]);
      send_pkt(8'h15, 3'd6, fd[4]);
      end_pkt();
      tick();
      tick();
      tick();
      check("fill_drops", 32'(fd), 32'b10000);
      check("fill_occ", 32'(bus.occupancy), 32'd4);
      check("fill_one_req", 32'(req_cnt - base), 32'd1);
      if (req_cnt > base) check("fill_head_port", 32'(req_ports[base]), 32'd1);
      replay(8'h11, 3'd1, "drain1");
      check("drain_occ3", 32'(bus.occupancy), 32'd3);
      wait_req(base + 2, 3'd2, "drain2");
      replay(8'h12, 3'd2, "drain2");
      wait_req(base + 3, 3'd3, "drain3");
      replay(8'h13, 3'd3, "drain3");
      wait_req(base + 4, 3'd4, "drain4");
      replay(8'h14, 3'd4, "drain4");
      check("drain_occ0", 32'(bus.occupancy), 32'd0);
      tick();

      // FIFO order 2,7,3; each request only after the previous replay.
      base = req_cnt;
      send_pkt(8'h31, 3'd2, d);
      send_pkt(8'h32, 3'd7, d);
      send_pkt(8'h33, 3'd3, d);
      end_pkt();
      tick();
      tick();
      check("order_occ", 32'(bus.occupancy), 32'd3);
      check("order_one_req", 32'(req_cnt - base), 32'd1);
      wait_req(base + 1, 3'd2, "order1");
      replay(8'h31, 3'd2, "order1");
      wait_req(base + 2, 3'd7, "order2");
      replay(8'h32, 3'd7, "order2");
      wait_req(base + 3, 3'd3, "order3");
      replay(8'h33, 3'd3, "order3");
      check("order_occ0", 32'(bus.occupancy), 32'd0);
      tick();

      // Commit of Z on the same edge as the last replay word of X, occupancy 2.
      base = req_cnt;
      send_pkt(8'h41, 3'd1, d);
      send_pkt(8'h42, 3'd4, d);
      end_pkt();
      wait_req(base + 1, 3'd1, "simul_x");
      bus.grant_buf.valid = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sop = 1'b1;
      bus.in_data = pkt_word(8'h43, 0, 3'd6);
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.grant_buf.valid = 1'b0;
         check($sformatf("simul_x_data%0d", i), bus.out_data, pkt_word(8'h41, i, 3'd1));
         if (i < 3) begin
            bus.in_sop = 1'b0;
            bus.in_data = pkt_word(8'h43, i + 1, 3'd6);
         end
      end
      check("simul_occ", 32'(bus.occupancy), 32'd2);
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      wait_req(base + 2, 3'd4, "simul_y");
      replay(8'h42, 3'd4, "simul_y");
      wait_req(base + 3, 3'd6, "simul_z");
      replay(8'h43, 3'd6, "simul_z");
      check("simul_occ0", 32'(bus.occupancy), 32'd0);
      tick();

      // Aborted capture: new sop at word 2.
      base = req_cnt;
      tick();
      bus.in_valid = 1'b1;
      bus.in_sop = 1'b1;
      bus.in_data = pkt_word(8'h51, 0, 3'd7);
      #1;
      check("abort_first_drop", 32'(bus.drop), 32'd0);
      tick();
      bus.in_sop = 1'b0;
      bus.in_data = pkt_word(8'h51, 1, 3'd7);
      tick();
      bus.in_sop = 1'b1;
      bus.in_data = pkt_word(8'h52, 0, 3'd2);
      #1;
      check("abort_drop", 32'(bus.drop), 32'd1);
      check("abort_occ0", 32'(bus.occupancy), 32'd0);
      for (int i = 1; i < 4; i++) begin
         tick();
         bus.in_sop = 1'b0;
         bus.in_data = pkt_word(8'h52, i, 3'd2);
      end
      end_pkt();
      check("abort_occ1", 32'(bus.occupancy), 32'd1);
      wait_req(base + 1, 3'd2, "abort");
      replay(8'h52, 3'd2, "abort");
      check("abort_occ_end", 32'(bus.occupancy), 32'd0);
      tick();
      check("abort_no_extra_req", 32'(req_cnt - base), 32'd1);

      // Reset asserted mid-replay.
      base = req_cnt;
      send_pkt(8'h61, 3'd3, d);
      end_pkt();
      wait_req(base + 1, 3'd3, "rstmid");
      bus.grant_buf.valid = 1'b1;
      tick();
      bus.grant_buf.valid = 1'b0;
      tick();
      check("rstmid_sending", 32'(bus.out_valid), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("rstmid_out", 32'(bus.out_valid), 32'd0);
      check("rstmid_req", 32'(bus.req_buf.valid), 32'd0);
      check("rstmid_occ", 32'(bus.occupancy), 32'd0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("rstmid_no_req", 32'(req_cnt - base), 32'd1);
      check("rstmid_idle_out", 32'(bus.out_valid), 32'd0);
      send_pkt(8'h62, 3'd4, d);
      end_pkt();
      wait_req(base + 2, 3'd4, "after_rst");
      replay(8'h62, 3'd4, "after_rst");
      check("after_rst_occ", 32'(bus.occupancy), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
